// File: rtl/percentage_aggregator.sv
// Collects one percentage report per dropoff station each epoch and publishes the
// saturated sum (R) and reporting-station count (G) once per epoch, double-buffered.
module percentage_aggregator #(
  parameter int MAX_STATIONS = 16,
  parameter int EPOCH_TICKS  = 60,
  parameter int INT          = 31
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            report_valid,
  input  logic [$clog2(MAX_STATIONS)-1:0] report_station_id,
  input  logic [INT:0]                    report_percentage,
  output logic [INT:0]                    total_percentage_stored,
  output logic [INT:0]                    number_of_stations,
  output logic                            totals_published,
  output logic                            epoch_empty,
  output logic                            duplicate_report
);

  localparam int TICK_W = (EPOCH_TICKS > 1) ? $clog2(EPOCH_TICKS) : 1;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(EPOCH_TICKS - 1);

  logic [TICK_W-1:0]       tick;
  logic [MAX_STATIONS-1:0] seen;
  logic [MAX_STATIONS-1:0] seen_next;
  logic [MAX_STATIONS-1:0] id_mask;
  logic [INT:0]            acc;
  logic [INT:0]            acc_next;
  logic [INT:0]            pop_next;
  logic [INT+1:0]          sum_wide;
  logic                    is_dup;
  logic                    accept;
  logic                    epoch_end;

  // An out-of-range station id shifts the mask to zero, so it is neither accepted nor a duplicate.
  always_comb begin
    id_mask   = MAX_STATIONS'(1) << report_station_id;
    is_dup    = report_valid && ((seen & id_mask) != '0);
    accept    = report_valid && !is_dup && (id_mask != '0);
    sum_wide  = {1'b0, acc} + {1'b0, report_percentage};
    acc_next  = acc;
    seen_next = seen;
    if (accept) begin
      acc_next  = sum_wide[INT+1] ? '1 : sum_wide[INT:0];
      seen_next = seen | id_mask;
    end
    pop_next = '0;
    for (int i = 0; i < MAX_STATIONS; i++) begin
      pop_next = pop_next + (INT+1)'(seen_next[i]);
    end
    epoch_end = (tick == LAST_TICK);
  end

  // The closing cycle's own report is folded in via seen_next/acc_next before publishing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick                    <= '0;
      seen                    <= '0;
      acc                     <= '0;
      total_percentage_stored <= '0;
      number_of_stations      <= (INT+1)'(1);
      totals_published        <= 1'b0;
      epoch_empty             <= 1'b0;
      duplicate_report        <= 1'b0;
    end else begin
      duplicate_report <= is_dup;
      totals_published <= 1'b0;
      epoch_empty      <= 1'b0;
      if (epoch_end) begin
        tick <= '0;
        seen <= '0;
        acc  <= '0;
        if (pop_next != '0) begin
          total_percentage_stored <= acc_next;
          number_of_stations      <= pop_next;
          totals_published        <= 1'b1;
        end else begin
          epoch_empty <= 1'b1;
        end
      end else begin
        tick <= tick + TICK_W'(1);
        seen <= seen_next;
        acc  <= acc_next;
      end
    end
  end

endmodule
